// File: rtl/axi_burst_rd.sv
// AXI4 read-burst master: one native burst request becomes INCR read(s) on AR/R.
// Optional 4KB boundary split enabled by defining AXI_BURST_RD_4K_SPLIT_EN.
module axi_burst_rd #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              error,
    output logic              m_axi_arid,
    output logic              m_axi_arlock,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic [3:0]        m_axi_arcache,
    output logic [1:0]        m_axi_arburst,
    output logic [2:0]        m_axi_arsize,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic              m_axi_rid,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [LEN_W:0]    CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PAGE_MASK = 'hFFF;

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] seg_addr, nxt_addr;
    logic [LEN_W-1:0]  seg_len, nxt_len, first_len;
    logic [LEN_W:0]    seg_cnt, remaining;
    logic              split_pend, first_split, beat;

    assign m_axi_arid    = 1'b0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arprot  = '0;
    assign m_axi_arqos   = '0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_araddr  = seg_addr;
    assign m_axi_arlen   = 8'(seg_len);

    assign beat = m_axi_rvalid && (state == R);

`ifdef AXI_BURST_RD_4K_SPLIT_EN
    logic [12:0]    b2b;
    logic [LEN_W:0] req_beats;

    always_comb begin
        b2b         = (13'h1000 - {1'b0, addr[11:0]}) >> SIZE;
        req_beats   = {1'b0, len} + CNT_ONE;
        first_split = 32'(req_beats) > 32'(b2b);
        first_len   = first_split ? LEN_W'(b2b - 13'd1) : len;
    end
`else
    assign first_split = 1'b0;
    assign first_len   = len;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi_rid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (valid) state_nxt = AR;
            end
            AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_nxt = R;
            end
            R: begin
                m_axi_rready = 1'b1;
                if (beat && m_axi_rlast)
                    state_nxt = (remaining > CNT_ONE && split_pend) ? AR : DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_addr   <= '0;
            seg_len    <= '0;
            seg_cnt    <= '0;
            remaining  <= '0;
            nxt_addr   <= '0;
            nxt_len    <= '0;
            split_pend <= 1'b0;
            rdata      <= '0;
            ready      <= 1'b0;
            error      <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: if (valid) begin
                    seg_addr   <= addr;
                    seg_len    <= first_len;
                    seg_cnt    <= {1'b0, first_len} + CNT_ONE;
                    remaining  <= {1'b0, len} + CNT_ONE;
                    split_pend <= first_split;
                    nxt_addr   <= (addr | PAGE_MASK) + ADDR_W'(1);
                    nxt_len    <= len - first_len - LEN_W'(1);
                    error      <= 1'b0;
                end
                R: if (beat) begin
                    ready <= 1'b1;
                    rdata <= m_axi_rdata;
                    if (m_axi_rresp != 2'b00) error <= 1'b1;
                    // counters saturate so over-long bursts only flag error until rlast
                    if (remaining != '0) remaining <= remaining - CNT_ONE;
                    if (seg_cnt != '0)   seg_cnt   <= seg_cnt - CNT_ONE;
                    if (m_axi_rlast) begin
                        if (seg_cnt != CNT_ONE) error <= 1'b1;
                        if (remaining > CNT_ONE) begin
                            if (split_pend) begin
                                seg_addr   <= nxt_addr;
                                seg_len    <= nxt_len;
                                seg_cnt    <= {1'b0, nxt_len} + CNT_ONE;
                                split_pend <= 1'b0;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end else if (seg_cnt <= CNT_ONE) begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_rd.sv
// Directed bench for axi_burst_rd with a scripted AXI read slave; split
// expectations follow AXI_BURST_RD_4K_SPLIT_EN.
module tb_axi_burst_rd;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [31:0]  addr;
    logic [7:0]   len;
    logic [255:0] rdata;
    logic         ready, busy, error;
    logic         m_axi_arid, m_axi_arlock;
    logic [2:0]   m_axi_arprot, m_axi_arsize;
    logic [3:0]   m_axi_arqos, m_axi_arcache;
    logic [1:0]   m_axi_arburst;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic         m_axi_arvalid, m_axi_arready;
    logic         m_axi_rid;
    logic [255:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;

    axi_burst_rd #(.ADDR_W(32), .DATA_W(256), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .len(len),
        .rdata(rdata), .ready(ready), .busy(busy), .error(error),
        .m_axi_arid(m_axi_arid), .m_axi_arlock(m_axi_arlock),
        .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arcache(m_axi_arcache), .m_axi_arburst(m_axi_arburst),
        .m_axi_arsize(m_axi_arsize), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // monitor state (written only by the monitor process)
    logic [255:0] got_q[$];
    logic [31:0]  ar_addr_q[$];
    logic [7:0]   ar_len_q[$];
    int           lat_err = 0;
    int           ar_unstable = 0;
    logic         exp_rdy = 1'b0;
    logic         prev_pend = 1'b0;
    logic [31:0]  p_addr;
    logic [7:0]   p_len;

    logic         err_at_accept;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] beat_data(input int idx);
        return {8{32'hA5A5_0000 | 32'(idx)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // At negedge, DUT outputs and bench inputs both hold the values seen at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_rdy   = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (ready !== exp_rdy) lat_err++;
            if (ready) got_q.push_back(rdata);
            exp_rdy = m_axi_rvalid && m_axi_rready;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_addr_q.push_back(m_axi_araddr);
                ar_len_q.push_back(m_axi_arlen);
            end
            if (prev_pend && (!m_axi_arvalid || m_axi_araddr != p_addr || m_axi_arlen != p_len))
                ar_unstable++;
            prev_pend = m_axi_arvalid && !m_axi_arready;
            p_addr    = m_axi_araddr;
            p_len     = m_axi_arlen;
        end
    end

    task automatic wait_arvalid();
        int t = 0;
        while (!m_axi_arvalid && t < 40) begin
            step();
            t++;
        end
        if (!m_axi_arvalid) check_eq("arvalid_timeout", 0, 1);
    endtask

    // Scripted slave: nseg AR handshakes, segment beat counts b0/b1 (rlast on each
    // segment's last beat), rresp=2'b10 on global beat index bad_resp.
    task automatic burst(input logic [31:0] a, input logic [7:0] l, input int nseg,
                         input int b0, input int b1, input int bad_resp,
                         input bit gap, input int ar_wait);
        int idx = 0;
        valid = 1'b1;
        addr  = a;
        len   = l;
        for (int s = 0; s < nseg; s++) begin
            int n = (s == 0) ? b0 : b1;
            wait_arvalid();
            if (s == 0) err_at_accept = error;
            repeat (ar_wait) step();
            m_axi_arready = 1'b1;
            step();
            m_axi_arready = 1'b0;
            for (int i = 0; i < n; i++) begin
                int t = 0;
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = beat_data(idx);
                m_axi_rlast  = (i == n - 1);
                m_axi_rresp  = (idx == bad_resp) ? 2'b10 : 2'b00;
                while (!m_axi_rready && t < 40) begin
                    step();
                    t++;
                end
                if (!m_axi_rready) check_eq("rready_timeout", 0, 1);
                step();
                idx++;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
                if (gap) step();
            end
        end
        valid = 1'b0;
    endtask

    task automatic check_beats(input string tag, input int base, input int n);
        int bad = 0;
        check_eq({tag, "_pulses"}, got_q.size() - base, n);
        for (int i = 0; i < n && base + i < got_q.size(); i++)
            if (got_q[base + i] !== beat_data(i)) bad++;
        check_eq({tag, "_order"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int gb, ab, lb;
        rst = 1'b1; valid = 1'b0; addr = '0; len = '0;
        m_axi_arready = 1'b0; m_axi_rid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        step(); step();

        check_eq("rst_arvalid", m_axi_arvalid, 0);
        check_eq("rst_rready", m_axi_rready, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("arsize", m_axi_arsize, 5);
        check_eq("arcache", m_axi_arcache, 4'b0011);
        check_eq("arburst", m_axi_arburst, 2'b01);
        rst = 1'b0;
        step();

        // single beat
        gb = got_q.size(); ab = ar_addr_q.size(); lb = lat_err;
        burst(32'h100, 8'd0, 1, 1, 0, -1, 1'b0, 0);
        check_eq("t1_ar_cnt", ar_addr_q.size() - ab, 1);
        check_eq("t1_araddr", ar_addr_q[ab], 32'h100);
        check_eq("t1_arlen", ar_len_q[ab], 0);
        check_eq("t1_ready_now", ready, 1);
        check_eq("t1_rdata", rdata, beat_data(0));
        check_eq("t1_busy_done", busy, 1);
        step();
        check_eq("t1_busy_idle", busy, 0);
        check_eq("t1_error", error, 0);
        check_beats("t1", gb, 1);
        check_eq("t1_latency", lat_err - lb, 0);
        step();

        // 16 beats, toggling rvalid, arready withheld 5 cycles
        gb = got_q.size(); ab = ar_addr_q.size(); lb = lat_err;
        burst(32'h2000, 8'd15, 1, 16, 0, -1, 1'b1, 5);
        step();
        check_eq("t2_ar_cnt", ar_addr_q.size() - ab, 1);
        check_eq("t2_araddr", ar_addr_q[ab], 32'h2000);
        check_eq("t2_arlen", ar_len_q[ab], 15);
        check_eq("t2_ar_stable", ar_unstable, 0);
        check_beats("t2", gb, 16);
        check_eq("t2_latency", lat_err - lb, 0);
        check_eq("t2_error", error, 0);

        // rresp error on beat 3 of 8
        gb = got_q.size();
        burst(32'h3000, 8'd7, 1, 8, 0, 2, 1'b0, 1);
        step();
        check_beats("t3", gb, 8);
        check_eq("t3_error", error, 1);
        check_eq("t3_busy", busy, 0);

        // early rlast on beat 4 of len=7; also shows the error clears on accept
        gb = got_q.size();
        burst(32'h4000, 8'd7, 1, 4, 0, -1, 1'b0, 0);
        check_eq("t4_err_cleared", err_at_accept, 0);
        check_eq("t4_busy_done", busy, 1);
        step();
        check_eq("t4_busy_idle", busy, 0);
        check_eq("t4_error", error, 1);
        check_beats("t4", gb, 4);

        // 4KB crossing: addr 0xFC0, 4 beats of 32 bytes
        gb = got_q.size(); ab = ar_addr_q.size();
`ifdef AXI_BURST_RD_4K_SPLIT_EN
        burst(32'hFC0, 8'd3, 2, 2, 2, -1, 1'b0, 0);
        step();
        check_eq("t5_ar_cnt", ar_addr_q.size() - ab, 2);
        check_eq("t5_araddr1", ar_addr_q[ab], 32'hFC0);
        check_eq("t5_arlen1", ar_len_q[ab], 1);
        check_eq("t5_araddr2", ar_addr_q[ab + 1], 32'h1000);
        check_eq("t5_arlen2", ar_len_q[ab + 1], 1);
`else
        burst(32'hFC0, 8'd3, 1, 4, 0, -1, 1'b0, 0);
        step();
        check_eq("t5_ar_cnt", ar_addr_q.size() - ab, 1);
        check_eq("t5_araddr", ar_addr_q[ab], 32'hFC0);
        check_eq("t5_arlen", ar_len_q[ab], 3);
`endif
        check_beats("t5", gb, 4);
        check_eq("t5_error", error, 0);

        // reset during R after 2 of 8 beats
        valid = 1'b1; addr = 32'h5000; len = 8'd7;
        wait_arvalid();
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beat_data(i);
            step();
        end
        m_axi_rvalid = 1'b0;
        check_eq("t6_ready_before", ready, 1);
        rst = 1'b1; valid = 1'b0;
        #1;
        check_eq("t6_arvalid", m_axi_arvalid, 0);
        check_eq("t6_rready", m_axi_rready, 0);
        check_eq("t6_ready", ready, 0);
        check_eq("t6_busy", busy, 0);
        step(); step();
        rst = 1'b0;
        step();

        // fresh request after reset
        gb = got_q.size(); ab = ar_addr_q.size();
        burst(32'h6000, 8'd1, 1, 2, 0, -1, 1'b0, 0);
        step();
        check_eq("t7_araddr", ar_addr_q[ab], 32'h6000);
        check_eq("t7_arlen", ar_len_q[ab], 1);
        check_beats("t7", gb, 2);
        check_eq("t7_error", error, 0);
        check_eq("t7_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
